// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
// The master issues load/store requests and the slave answers with one response each.
interface data_mem_ctrl_if #(
    parameter int unsigned AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory with load/store handshake, one-cycle response
// latency, alignment/range error checking and a self-clearing sweep after every reset.
module data_mem_ctrl #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus,
    output logic           init_done
);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] addr;
    logic [1:0]    lane;
    logic [IW-1:0] widx;
    logic [31:0]   word_rd;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    logic          err_c;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c;
    logic [31:0]   ld_data_c;
    logic          req_ready_c;
    logic          clr_we_c;
    logic          accept_c;

    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    assign addr    = bus.req_addr;
    assign lane    = addr[1:0];
    assign widx    = addr[IW+1:2];
    assign word_rd = mem[widx];
    assign ld_byte = word_rd[{lane, 3'b000} +: 8];
    assign ld_half = addr[1] ? word_rd[31:16] : word_rd[15:0];

    // Request decode: lane enables, replicated store data, extended load data, error
    always_comb begin
        err_c     = 1'b0;
        be_c      = 4'b0000;
        wdata_c   = 32'd0;
        ld_data_c = 32'd0;
        case (bus.req_size)
            2'd0: begin
                be_c      = 4'b0001 << lane;
                wdata_c   = {4{bus.req_wdata[7:0]}};
                ld_data_c = bus.req_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            2'd1: begin
                err_c     = addr[0];
                be_c      = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c   = {2{bus.req_wdata[15:0]}};
                ld_data_c = bus.req_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            2'd2: begin
                err_c     = (lane != 2'd0);
                be_c      = 4'b1111;
                wdata_c   = bus.req_wdata;
                ld_data_c = word_rd;
            end
            default: err_c = 1'b1;
        endcase
        // Any address bit above the word index means the word lies outside the array
        if ((addr >> (IW + 2)) != '0) begin
            err_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (idx == IW'(DEPTH - 1)) state_next = IDLE;
            IDLE:    if (rsp_valid_q && !bus.rsp_ready) state_next = HOLD;
            HOLD:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        req_ready_c = 1'b0;
        clr_we_c    = 1'b0;
        case (state)
            CLEAR:   clr_we_c    = 1'b1;
            IDLE:    req_ready_c = !rsp_valid_q || bus.rsp_ready;
            default: ;
        endcase
    end

    assign accept_c = bus.req_valid && req_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clr_we_c) begin
            idx <= idx + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done <= 1'b0;
        end else if (state == CLEAR && state_next == IDLE) begin
            init_done <= 1'b1;
        end
    end

    // Memory array carries no reset; the clearing sweep initialises it
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[idx] <= 32'd0;
        end else if (accept_c && bus.req_we && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[widx][8*b +: 8] <= wdata_c[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else if (accept_c) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_c;
            rsp_rdata_q <= (bus.req_we || err_c) ? 32'd0 : ld_data_c;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed spec scenarios plus a randomized stream scored
// against a byte-array reference model.
module tb_data_mem_ctrl;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned NBYTES = DEPTH * 4;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic init_done;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.AW(32)) bus ();

    data_mem_ctrl #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mbytes [NBYTES];
    req_t       reqs[$];
    bit         rdy_pat[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
    endtask

    // Reference: n = 2**size bytes, must be naturally aligned and inside the array
    task automatic model_req(input req_t r, output logic err, output logic [31:0] data);
        int     n;
        longint v;
        longint lim;
        err  = 1'b0;
        data = 32'd0;
        n    = 1 << r.size;
        if (r.size == 2'd3 || (r.addr % n) != 0 || r.addr >= NBYTES) begin
            err = 1'b1;
            return;
        end
        if (r.we) begin
            for (int i = 0; i < n; i++) mbytes[r.addr + i] = r.wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mbytes[r.addr + i]);
            lim = longint'(1) << (8 * n);
            if (!r.uns && n < 4 && v >= lim / 2) v = v - lim;
            data = 32'(v);
        end
    endtask

    task automatic drive(input req_t r);
        bus.req_we       = r.we;
        bus.req_size     = r.size;
        bus.req_unsigned = r.uns;
        bus.req_addr     = r.addr;
        bus.req_wdata    = r.wdata;
        bus.req_valid    = 1'b1;
    endtask

    // Asserts reset now, checks forced outputs, then measures the clearing sweep
    task automatic do_reset(input string tag);
        int cnt;
        bit rdy_seen;
        cnt = 0;
        rdy_seen = 1'b0;
        rst = 1'b1;
        #1;
        check({tag, "_rst_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rst_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_rst_init_done"}, 32'(init_done), 32'd0);
        check({tag, "_rst_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, "_rst_err"}, 32'(bus.rsp_err), 32'd0);
        bus.rsp_ready = 1'b1;
        drive(mk(1'b0, 2'd2, 1'b0, 32'h1FC, 32'd0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        while (!init_done && cnt < 300) begin
            if (bus.req_ready) rdy_seen = 1'b1;
            cnt++;
            @(negedge clk);
            #1;
        end
        check({tag, "_clear_cycles"}, 32'(cnt), 32'd128);
        check({tag, "_ready_in_clear"}, 32'(rdy_seen), 32'd0);
        check({tag, "_ready_after_clear"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check({tag, "_ld1fc_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_ld1fc_data"}, bus.rsp_rdata, 32'd0);
        check({tag, "_ld1fc_err"}, 32'(bus.rsp_err), 32'd0);
    endtask

    // One isolated request checked against explicit expected values
    task automatic single(input string tag, input req_t r, input logic exp_err,
                          input logic [31:0] exp_data);
        logic        me;
        logic [31:0] md;
        int          w;
        @(negedge clk);
        drive(r);
        bus.rsp_ready = 1'b1;
        w = 0;
        #1;
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, "_accept"}, 32'(w < 50), 32'd1);
        @(posedge clk);
        model_req(r, me, md);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_data"}, bus.rsp_rdata, exp_data);
    endtask

    // Streams the queued requests with back-pressure; every response is scored in order
    task automatic run_stream(input bit rnd, output int n_acc, output int n_cons);
        logic        eq_err[$];
        logic [31:0] eq_dat[$];
        bit          prev_held;
        bit          just_acc;
        logic [31:0] prev_dat;
        logic        prev_err;
        logic        me;
        logic [31:0] md;
        bit          acc;
        bit          cons;
        int          cyc;
        prev_held = 1'b0; just_acc = 1'b0; prev_dat = '0; prev_err = 1'b0; cyc = 0;
        n_acc = 0;
        n_cons = 0;
        while ((reqs.size() > 0 || eq_dat.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            if (reqs.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) drive(reqs[0]);
            else bus.req_valid = 1'b0;
            if (rdy_pat.size() > 0) bus.rsp_ready = rdy_pat.pop_front();
            else bus.rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (just_acc) check("latency1_valid", 32'(bus.rsp_valid), 32'd1);
            if (prev_held) begin
                check("held_valid", 32'(bus.rsp_valid), 32'd1);
                check("held_data", bus.rsp_rdata, prev_dat);
                check("held_err", 32'(bus.rsp_err), 32'(prev_err));
            end
            if (bus.rsp_valid && !bus.rsp_ready) check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            if (!bus.rsp_valid) check("empty_rsp_zero", {bus.rsp_rdata[31:1], bus.rsp_rdata[0] | bus.rsp_err}, 32'd0);
            acc  = bus.req_valid && bus.req_ready;
            cons = bus.rsp_valid && bus.rsp_ready;
            if (cons) begin
                check("rsp_expected", 32'(eq_dat.size() != 0), 32'd1);
                if (eq_dat.size() != 0) begin
                    check("rsp_err", 32'(bus.rsp_err), 32'(eq_err.pop_front()));
                    check("rsp_data", bus.rsp_rdata, eq_dat.pop_front());
                end
                n_cons++;
            end
            if (acc) begin
                model_req(reqs.pop_front(), me, md);
                eq_err.push_back(me);
                eq_dat.push_back(md);
                n_acc++;
            end
            prev_held = bus.rsp_valid && !bus.rsp_ready;
            prev_dat  = bus.rsp_rdata;
            prev_err  = bus.rsp_err;
            just_acc  = acc;
            cyc++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        check("stream_no_timeout", 32'(cyc < 20000), 32'd1);
        check("stream_no_extra_rsp", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int   na;
        int   nc;
        req_t r;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.rsp_ready    = 1'b1;
        #2;
        do_reset("init");

        single("st_w10", mk(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01), 1'b0, 32'd0);
        single("ld_bs13", mk(1'b0, 2'd0, 1'b0, 32'h13, 32'd0), 1'b0, 32'hFFFFFF80);
        single("ld_bu11", mk(1'b0, 2'd0, 1'b1, 32'h11, 32'd0), 1'b0, 32'h0000007F);
        single("ld_hs12", mk(1'b0, 2'd1, 1'b0, 32'h12, 32'd0), 1'b0, 32'hFFFF80FF);
        single("ld_hu12", mk(1'b0, 2'd1, 1'b1, 32'h12, 32'd0), 1'b0, 32'h000080FF);

        single("st_w20", mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344), 1'b0, 32'd0);
        single("st_b21", mk(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFFAB), 1'b0, 32'd0);
        single("ld_w20", mk(1'b0, 2'd2, 1'b0, 32'h20, 32'd0), 1'b0, 32'h1122AB44);

        single("err_h03", mk(1'b0, 2'd1, 1'b0, 32'h03, 32'd0), 1'b1, 32'd0);
        single("err_sw22", mk(1'b1, 2'd2, 1'b0, 32'h22, 32'hDEADBEEF), 1'b1, 32'd0);
        single("err_sz3", mk(1'b0, 2'd3, 1'b0, 32'h20, 32'd0), 1'b1, 32'd0);
        single("err_sz3st", mk(1'b1, 2'd3, 1'b0, 32'h24, 32'hDEADBEEF), 1'b1, 32'd0);
        single("err_w200", mk(1'b0, 2'd2, 1'b0, 32'h200, 32'd0), 1'b1, 32'd0);
        single("err_sw200", mk(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF), 1'b1, 32'd0);
        single("err_hi", mk(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEADBEEF), 1'b1, 32'd0);
        single("keep_w20", mk(1'b0, 2'd2, 1'b0, 32'h20, 32'd0), 1'b0, 32'h1122AB44);
        single("keep_w24", mk(1'b0, 2'd2, 1'b0, 32'h24, 32'd0), 1'b0, 32'h00000000);
        single("keep_w00", mk(1'b0, 2'd2, 1'b0, 32'h00, 32'd0), 1'b0, 32'h00000000);
        single("keep_w10", mk(1'b0, 2'd2, 1'b0, 32'h10, 32'd0), 1'b0, 32'h80FF7F01);

        // Store immediately followed by loads of the same word
        reqs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEBABE));
        reqs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h40, 32'd0));
        reqs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000005A));
        reqs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h40, 32'd0));
        reqs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h42, 32'h00009876));
        reqs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h43, 32'd0));
        run_stream(1'b0, na, nc);
        check("fwd_accepts", 32'(na), 32'd6);
        check("fwd_responses", 32'(nc), 32'd6);

        // Three back-to-back loads, response path stalled two cycles after the first
        reqs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'd0));
        reqs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'd0));
        reqs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h13, 32'd0));
        rdy_pat = '{1'b1, 1'b0, 1'b0};
        run_stream(1'b0, na, nc);
        check("b2b_accepts", 32'(na), 32'd3);
        check("b2b_responses", 32'(nc), 32'd3);

        // Reset while a stalled response is held
        @(negedge clk);
        drive(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'd0));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        check("hold_before_rst", 32'(bus.rsp_valid), 32'd1);
        do_reset("hold");
        single("post_rst_w20", mk(1'b0, 2'd2, 1'b0, 32'h20, 32'd0), 1'b0, 32'h00000000);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            r.we    = 1'($urandom_range(0, 1));
            r.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r.uns   = 1'($urandom_range(0, 1));
            r.addr  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 'h21F))
                                                  : 32'($urandom_range(0, 'h3F));
            if ($urandom_range(0, 19) == 0) r.addr = r.addr | 32'h0001_0000;
            r.wdata = $urandom;
            if (r.size != 2'd3 && $urandom_range(0, 3) != 0)
                r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
            reqs.push_back(r);
        end
        run_stream(1'b1, na, nc);
        check("rand_accepts", 32'(na), 32'd400);
        check("rand_responses", 32'(nc), 32'd400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
